fft_butterfly_scheduler: RTL and testbench
==========================================

# fft_butterfly_scheduler

Sequencer for an in-place radix-2 decimation-in-time FFT. It drives a single shared `FFT_Base_Butterfly`/`FFT_Calc` datapath, issuing one butterfly per cycle over all stages. For each butterfly it generates the even/odd sample-memory read addresses, the twiddle index and stage number, and it delays those addresses to produce the write-back. It sits between the frame buffer, which holds bit-reversed input, and the shared butterfly, and signals completion to the frame controller.

## Interface
Parameters:
- `num_points`, 16: FFT length N; must be a power of two, at least 4.
- `LOG2N`, `$clog2(num_points)`: derived, not overridden; the number of stages.
- `stage_width`, `max(1, $clog2(LOG2N))`: derived; width of `stage`.

Ports:
- `clk`  in  1  the single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request an FFT pass; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse at the end of the pass.
- `rd_en`  out  1  a butterfly operand read is issued this cycle.
- `rd_addr_even`  out  LOG2N  even operand address.
- `rd_addr_odd`  out  LOG2N  odd operand address.
- `twiddle_index`  out  max(1, LOG2N-1)  index into the N/2-entry twiddle ROM.
- `stage`  out  stage_width  current stage, 0..LOG2N-1.
- `wr_en`  out  1  write back the butterfly sum and difference.
- `wr_addr_even`  out  LOG2N  destination for the sum term.
- `wr_addr_odd`  out  LOG2N  destination for the difference term.

## Operation
States:
- IDLE: waits for `start`; moves to RUN.
- RUN: one butterfly per cycle with `rd_en`=1; counter k runs 0..N/2-1. At k=N/2-1 the next state is GAP if the stage is below LOG2N-1, otherwise FLUSH.
- GAP: one bubble cycle with `rd_en`=0. The stage increments, k resets to 0, and the next state is RUN.
- FLUSH: one cycle with `rd_en`=0 that lets the final write-back complete; next state is DONE.
- DONE: `done`=1 for one cycle; next state is IDLE.

Address arithmetic, with s = stage and span = 2^s:
- even = ((k >> s) << (s+1)) | (k & (span-1))
- odd = even + span
- `twiddle_index` = (k & (span-1)) << (LOG2N-1-s)

Write-back:
- `wr_en`, `wr_addr_even` and `wr_addr_odd` are the read-side values registered once, so they lag the read by 1 cycle.
- The memory read latency is 1 cycle; the butterfly is combinational on the memory output.

GAP purpose: it guarantees that no next-stage read overlaps the previous stage's final write. Within a stage, addresses are disjoint across k.

Other rules:
- `start` while `busy` is ignored.
- `start` held high in IDLE after `done` begins a new pass, since IDLE samples it.
- The block has no input bit-reversal; the loader places data in bit-reversed order.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset asserted mid-pass aborts on the next edge; `wr_en` is 0 on the cycle after reset even if a read was in flight.
- When `start` is sampled at edge 0, the first `rd_en` appears in cycle 1.
- Pass length is LOG2N·N/2 RUN cycles plus LOG2N-1 GAP cycles, then FLUSH, then DONE. For N=16 that gives:
  - `rd_en` in cycles 1–35, excluding the GAP cycles 9, 18 and 27;
  - the last `wr_en` in cycle 36 (FLUSH);
  - `done` in cycle 37.
- `busy` rises in cycle 1 and falls after cycle 37.
- Outputs `stage` and `twiddle_index` are valid only while `rd_en`=1; otherwise they hold their last value.

## Configuration
- Macro `FFT_SCHED_INVERSE_EN`.
- Defined:
  - The block adds the input `inverse` (1 bit, sampled with `start`) and the output `twiddle_conj` (1 bit).
  - `twiddle_conj` equals the latched `inverse` for the whole pass. The datapath negates the twiddle imaginary part when it is high.
  - `twiddle_conj` resets to 0.
- Not defined: neither port exists, and there is no inverse capability.

## Test plan
- **Reset:** assert `reset` mid-pass at cycle 10. All outputs are 0 on the next cycle, the state is IDLE, and a fresh `start` yields the first `rd_en` 1 cycle later.
- **Stage 0, N=16:** k=0..7 gives even/odd pairs 0/1, 2/3, …, 14/15 with `twiddle_index`=0.
- **Stage 2, N=16:** k=5 gives even=9, odd=13, `twiddle_index`=2. Stage 3, k=7 gives even=7, odd=15, `twiddle_index`=7.
- **Full pass, N=16:**
  - 32 `rd_en` pulses and 32 `wr_en` pulses;
  - each write address equals the read address 1 cycle earlier;
  - `rd_en` is 0 in cycles 9, 18 and 27;
  - `done` pulses only in cycle 37.
- **Start while busy:** `start` pulsed in cycle 5 is ignored and the pass length is unchanged. Holding `start` high continuously gives back-to-back passes with `busy` low for exactly 1 cycle (IDLE).
- **With `FFT_SCHED_INVERSE_EN`:** `inverse`=1 at `start` gives `twiddle_conj`=1 through `done`; the next pass with `inverse`=0 gives 0.

Source files
------------

// File: rtl/fft_butterfly_scheduler_if.sv
// Handshake and address bus between the FFT butterfly scheduler and its datapath.
// FFT_SCHED_INVERSE_EN adds the inverse request and the twiddle conjugate flag.
interface fft_butterfly_scheduler_if #(
    parameter int num_points = 16
);
    localparam int LOG2N       = $clog2(num_points);
    localparam int stage_width = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1;
    localparam int tw_width    = (LOG2N - 1 > 1) ? LOG2N - 1 : 1;

    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   rd_en;
    logic [LOG2N-1:0]       rd_addr_even;
    logic [LOG2N-1:0]       rd_addr_odd;
    logic [tw_width-1:0]    twiddle_index;
    logic [stage_width-1:0] stage;
    logic                   wr_en;
    logic [LOG2N-1:0]       wr_addr_even;
    logic [LOG2N-1:0]       wr_addr_odd;
`ifdef FFT_SCHED_INVERSE_EN
    logic                   inverse;
    logic                   twiddle_conj;

    modport master (
        input  start, inverse,
        output busy, done, rd_en, rd_addr_even, rd_addr_odd, twiddle_index,
               stage, wr_en, wr_addr_even, wr_addr_odd, twiddle_conj
    );
    modport slave (
        output start, inverse,
        input  busy, done, rd_en, rd_addr_even, rd_addr_odd, twiddle_index,
               stage, wr_en, wr_addr_even, wr_addr_odd, twiddle_conj
    );
`else
    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_even, rd_addr_odd, twiddle_index,
               stage, wr_en, wr_addr_even, wr_addr_odd
    );
    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_even, rd_addr_odd, twiddle_index,
               stage, wr_en, wr_addr_even, wr_addr_odd
    );
`endif
endinterface

// File: rtl/fft_butterfly_scheduler.sv
// In-place radix-2 DIT FFT sequencer: one butterfly per cycle, write-back one cycle behind.
// Optional inverse-FFT twiddle conjugation is enabled by FFT_SCHED_INVERSE_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing butterfly k of the current stage
// GAP   | bubble between stages so the last write lands before the next read
// FLUSH | final write-back drains
// DONE  | one-cycle completion pulse
module fft_butterfly_scheduler #(
    parameter int num_points = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    fft_butterfly_scheduler_if.master  bus
);
    localparam int LOG2N       = $clog2(num_points);
    localparam int stage_width = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1;
    localparam int tw_width    = (LOG2N - 1 > 1) ? LOG2N - 1 : 1;
    localparam int KW          = LOG2N - 1;
    localparam logic [KW-1:0]          K_LAST = KW'(num_points / 2 - 1);
    localparam logic [stage_width-1:0] S_LAST = stage_width'(LOG2N - 1);

    typedef enum logic [2:0] {IDLE, RUN, GAP, FLUSH, DONE} state_t;

    state_t                 state, state_next;
    logic [KW-1:0]          k_q, k_next;
    logic [stage_width-1:0] s_q, s_next;

    logic                   busy_q, done_q, rd_en_q, wr_en_q;
    logic [LOG2N-1:0]       rd_even_q, rd_odd_q, wr_even_q, wr_odd_q;
    logic [tw_width-1:0]    tw_q;
    logic [stage_width-1:0] stage_q;

    function automatic logic [LOG2N-1:0] span_of(input logic [stage_width-1:0] s);
        return LOG2N'(1) << s;
    endfunction

    function automatic logic [LOG2N-1:0] even_of(input logic [KW-1:0] k,
                                                 input logic [stage_width-1:0] s);
        logic [LOG2N-1:0] kw;
        logic [LOG2N-1:0] mask;
        kw   = {1'b0, k};
        mask = span_of(s) - LOG2N'(1);
        return ((kw >> s) << (int'(s) + 1)) | (kw & mask);
    endfunction

    function automatic logic [tw_width-1:0] twiddle_of(input logic [KW-1:0] k,
                                                       input logic [stage_width-1:0] s);
        logic [LOG2N-1:0] kw;
        logic [LOG2N-1:0] t;
        kw = {1'b0, k};
        t  = (kw & (span_of(s) - LOG2N'(1))) << (LOG2N - 1 - int'(s));
        return t[tw_width-1:0];
    endfunction

    always_comb begin
        state_next = state;
        k_next     = k_q;
        s_next     = s_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    k_next     = '0;
                    s_next     = '0;
                end
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    state_next = (s_q == S_LAST) ? FLUSH : GAP;
                end else begin
                    k_next = k_q + KW'(1);
                end
            end
            GAP: begin
                state_next = RUN;
                k_next     = '0;
                s_next     = s_q + stage_width'(1);
            end
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k_q       <= '0;
            s_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_even_q <= '0;
            rd_odd_q  <= '0;
            tw_q      <= '0;
            stage_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_even_q <= '0;
            wr_odd_q  <= '0;
        end else begin
            state     <= state_next;
            k_q       <= k_next;
            s_q       <= s_next;
            busy_q    <= (state_next != IDLE);
            done_q    <= (state_next == DONE);
            rd_en_q   <= (state_next == RUN);
            if (state_next == RUN) begin
                rd_even_q <= even_of(k_next, s_next);
                rd_odd_q  <= even_of(k_next, s_next) + span_of(s_next);
                tw_q      <= twiddle_of(k_next, s_next);
                stage_q   <= s_next;
            end
            wr_en_q   <= rd_en_q;
            wr_even_q <= rd_even_q;
            wr_odd_q  <= rd_odd_q;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.rd_en         = rd_en_q;
    assign bus.rd_addr_even  = rd_even_q;
    assign bus.rd_addr_odd   = rd_odd_q;
    assign bus.twiddle_index = tw_q;
    assign bus.stage         = stage_q;
    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr_even  = wr_even_q;
    assign bus.wr_addr_odd   = wr_odd_q;

`ifdef FFT_SCHED_INVERSE_EN
    logic conj_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            conj_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            conj_q <= bus.inverse;
        end
    end

    assign bus.twiddle_conj = conj_q;
`endif
endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Directed bench for fft_butterfly_scheduler at N=16; covers the inverse option when
// FFT_SCHED_INVERSE_EN is defined.
module tb_fft_butterfly_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fft_butterfly_scheduler_if #(.num_points(16)) bus ();

    fft_butterfly_scheduler #(.num_points(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle c counted from the start edge: RUN cycles for stage s are 9*s+1 .. 9*s+8.
    function automatic bit exp_rd(input int c);
        return (c >= 1) && (c <= 35) && (((c - 1) % 9) != 8);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_done"},  32'(bus.done), 0);
        chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
        chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
        chk({tag, "_rd_ev"}, 32'(bus.rd_addr_even), 0);
        chk({tag, "_rd_od"}, 32'(bus.rd_addr_odd), 0);
        chk({tag, "_tw"},    32'(bus.twiddle_index), 0);
        chk({tag, "_stage"}, 32'(bus.stage), 0);
        chk({tag, "_wr_ev"}, 32'(bus.wr_addr_even), 0);
        chk({tag, "_wr_od"}, 32'(bus.wr_addr_odd), 0);
    endtask

    initial begin
        int s, k, span, ev, od, tw, pe, po, rd_cnt, wr_cnt, c, done_at;
        bit erd, ewr;

        reset     = 1'b1;
        bus.start = 1'b0;
`ifdef FFT_SCHED_INVERSE_EN
        bus.inverse = 1'b0;
`endif
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Full pass with per-cycle expectations
        pe = 0; po = 0; rd_cnt = 0; wr_cnt = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cy = 1; cy <= 37; cy++) begin
            s    = (cy - 1) / 9;
            k    = (cy - 1) % 9;
            span = 1 << s;
            erd  = exp_rd(cy);
            ewr  = (cy >= 2) && exp_rd(cy - 1);
            chk($sformatf("rd_en_c%0d", cy), 32'(bus.rd_en), 32'(erd));
            chk($sformatf("wr_en_c%0d", cy), 32'(bus.wr_en), 32'(ewr));
            chk($sformatf("busy_c%0d", cy),  32'(bus.busy), 1);
            chk($sformatf("done_c%0d", cy),  32'(bus.done), 32'(cy == 37));
            if (ewr) begin
                chk($sformatf("wr_ev_c%0d", cy), 32'(bus.wr_addr_even), 32'(pe));
                chk($sformatf("wr_od_c%0d", cy), 32'(bus.wr_addr_odd), 32'(po));
            end
            if (erd) begin
                ev = (k / span) * 2 * span + (k % span);
                od = ev + span;
                tw = (k % span) * (8 / span);
                chk($sformatf("rd_ev_c%0d", cy), 32'(bus.rd_addr_even), 32'(ev));
                chk($sformatf("rd_od_c%0d", cy), 32'(bus.rd_addr_odd), 32'(od));
                chk($sformatf("tw_c%0d", cy),    32'(bus.twiddle_index), 32'(tw));
                chk($sformatf("stage_c%0d", cy), 32'(bus.stage), 32'(s));
                pe = ev;
                po = od;
            end else if (cy <= 35) begin
                chk($sformatf("gap_stage_hold_c%0d", cy), 32'(bus.stage), 32'(s));
            end
            if (bus.rd_en === 1'b1) rd_cnt++;
            if (bus.wr_en === 1'b1) wr_cnt++;
            tick();
        end
        chk("rd_pulses", 32'(rd_cnt), 32);
        chk("wr_pulses", 32'(wr_cnt), 32);
        chk("idle_busy_c38", 32'(bus.busy), 0);
        chk("idle_rd_c38",   32'(bus.rd_en), 0);
        tick();

        // Start pulsed mid-pass is ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 1;
        done_at = 0;
        while (c <= 60 && done_at == 0) begin
            if (bus.done === 1'b1) begin
                done_at = c;
            end else begin
                if (c == 5) bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                c++;
            end
        end
        chk("busy_start_done_cycle", 32'(done_at), 37);
        tick();
        chk("busy_start_idle_busy", 32'(bus.busy), 0);
        tick();
        chk("busy_start_no_rerun_rd", 32'(bus.rd_en), 0);
        chk("busy_start_no_rerun_busy", 32'(bus.busy), 0);

        // Start held high: back-to-back passes, one IDLE cycle between
`ifdef FFT_SCHED_INVERSE_EN
        bus.inverse = 1'b1;
`endif
        bus.start = 1'b1;
        tick();
`ifdef FFT_SCHED_INVERSE_EN
        bus.inverse = 1'b0;
        chk("inv_conj_c1", 32'(bus.twiddle_conj), 1);
`endif
        c = 1;
        done_at = 0;
        while (c <= 60 && done_at == 0) begin
            if (bus.done === 1'b1) begin
                done_at = c;
            end else begin
                tick();
                c++;
            end
        end
        chk("b2b_first_done", 32'(done_at), 37);
`ifdef FFT_SCHED_INVERSE_EN
        chk("inv_conj_at_done", 32'(bus.twiddle_conj), 1);
`endif
        tick();
        chk("b2b_gap_busy_c38", 32'(bus.busy), 0);
        chk("b2b_gap_rd_c38",   32'(bus.rd_en), 0);
        tick();
        chk("b2b_busy_c39", 32'(bus.busy), 1);
        chk("b2b_rd_c39",   32'(bus.rd_en), 1);
`ifdef FFT_SCHED_INVERSE_EN
        chk("inv_conj_second_pass", 32'(bus.twiddle_conj), 0);
`endif
        c = 39;
        done_at = 0;
        while (c <= 100 && done_at == 0) begin
            if (bus.done === 1'b1) begin
                done_at = c;
            end else begin
                tick();
                c++;
            end
        end
        chk("b2b_second_done", 32'(done_at), 75);
        bus.start = 1'b0;
        tick();
        chk("b2b_end_busy", 32'(bus.busy), 0);
        tick();
        chk("b2b_end_stays_idle", 32'(bus.busy), 0);

        // Reset mid-pass while a read is in flight
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        chk("rst_mid_rd_c10", 32'(bus.rd_en), 1);
        reset = 1'b1;
        tick();
        chk_all_zero("rst_mid");
        reset = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("rst_restart_rd",    32'(bus.rd_en), 1);
        chk("rst_restart_ev",    32'(bus.rd_addr_even), 0);
        chk("rst_restart_od",    32'(bus.rd_addr_odd), 1);
        chk("rst_restart_wr_en", 32'(bus.wr_en), 0);
        c = 1;
        done_at = 0;
        while (c <= 60 && done_at == 0) begin
            if (bus.done === 1'b1) begin
                done_at = c;
            end else begin
                tick();
                c++;
            end
        end
        chk("rst_restart_done", 32'(done_at), 37);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
